// File: rtl/avalon_packet_arbiter_if.sv
// Avalon-ST stream bundle: data, valid, sop, eop and empty travel from the
// master to the slave, and rdy travels back.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             valid;
    logic                             sop;
    logic                             eop;
    logic [EW-1:0]                    empty;
    logic                             rdy;

    modport master (output data, valid, sop, eop, empty, input rdy);
    modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_packet_arbiter.sv
// Packet-level round-robin arbiter: one of NUM_INPUTS Avalon-ST requesters
// owns the shared output from its sop beat until its eop beat is accepted.
// The data path is a pure combinational mux; only the grant is registered.
module avalon_packet_arbiter #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int NUM_INPUTS          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    avalon_st_if.slave            in_msg [NUM_INPUTS],
    avalon_st_if.master           out_msg,
    output logic [NUM_INPUTS-1:0] grant_onehot,
    output logic                  busy,
    output logic [NUM_INPUTS-1:0] dropped_beat_indi
);
    localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
    localparam int GW = $clog2(NUM_INPUTS);

    typedef enum logic {
        IDLE,
        TRANSFER
    } state_t;

    state_t                state_q;
    logic [GW-1:0]         grant_q;
    logic [GW-1:0]         last_grant_q;
    logic                  busy_q;
    logic [NUM_INPUTS-1:0] grant_onehot_q;

    logic [DW-1:0]         in_data  [NUM_INPUTS];
    logic [EW-1:0]         in_empty [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] in_valid;
    logic [NUM_INPUTS-1:0] in_sop;
    logic [NUM_INPUTS-1:0] in_eop;
    logic [NUM_INPUTS-1:0] in_rdy;
    logic [NUM_INPUTS-1:0] drop_d;

    logic [NUM_INPUTS-1:0] cand;
    logic [GW:0]           pick_d;
    logic                  eop_accept;

    // Flatten the interface array so the granted input can be selected by a
    // run-time index.
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
        assign in_data[gi]    = in_msg[gi].data;
        assign in_empty[gi]   = in_msg[gi].empty;
        assign in_valid[gi]   = in_msg[gi].valid;
        assign in_sop[gi]     = in_msg[gi].sop;
        assign in_eop[gi]     = in_msg[gi].eop;
        assign in_msg[gi].rdy = in_rdy[gi];
    end

    // First set bit of cand scanning last+1, last+2, ... modulo NUM_INPUTS.
    // Result MSB is the found flag; the loop runs backwards so the nearest
    // candidate overwrites any farther one.
    function automatic logic [GW:0] rr_pick(input logic [NUM_INPUTS-1:0] req,
                                            input logic [GW-1:0]         last);
        logic [GW:0]   res;
        logic [GW-1:0] idx_v;
        int            idx;
        res = '0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            idx   = (int'(last) + k) % NUM_INPUTS;
            idx_v = GW'(idx);
            if (req[idx_v]) begin
                res = {1'b1, idx_v};
            end
        end
        return res;
    endfunction

    assign cand       = in_valid & in_sop;
    assign pick_d     = rr_pick(cand, last_grant_q);
    assign eop_accept = busy_q && in_valid[grant_q] && in_eop[grant_q] && out_msg.rdy;

    // Grant FSM: pick a winner in IDLE, hold it until the eop beat is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            last_grant_q   <= GW'(NUM_INPUTS - 1);
            busy_q         <= 1'b0;
            grant_onehot_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_d[GW]) begin
                        state_q        <= TRANSFER;
                        grant_q        <= pick_d[GW-1:0];
                        busy_q         <= 1'b1;
                        grant_onehot_q <= {{(NUM_INPUTS-1){1'b0}}, 1'b1} << pick_d[GW-1:0];
                    end
                end
                TRANSFER: begin
                    if (eop_accept) begin
                        state_q        <= IDLE;
                        last_grant_q   <= grant_q;
                        busy_q         <= 1'b0;
                        grant_onehot_q <= '0;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    busy_q         <= 1'b0;
                    grant_onehot_q <= '0;
                end
            endcase
        end
    end

    // Output mux and ready steering; stray beats are swallowed only while idle
    // and out of reset, so rdy and drop pulses stay low during reset.
    always_comb begin
        out_msg.data  = '0;
        out_msg.valid = 1'b0;
        out_msg.sop   = 1'b0;
        out_msg.eop   = 1'b0;
        out_msg.empty = '0;
        in_rdy        = '0;
        drop_d        = '0;
        if (busy_q) begin
            out_msg.data    = in_data[grant_q];
            out_msg.valid   = in_valid[grant_q];
            out_msg.sop     = in_sop[grant_q];
            out_msg.eop     = in_eop[grant_q];
            out_msg.empty   = in_empty[grant_q];
            in_rdy[grant_q] = out_msg.rdy;
        end else if (rst) begin
            drop_d = in_valid & ~in_sop;
            in_rdy = drop_d;
        end
    end

    assign grant_onehot      = grant_onehot_q;
    assign busy              = busy_q;
    assign dropped_beat_indi = drop_d;
endmodule

// File: tb/tb_avalon_packet_arbiter.sv
`timescale 1ns/1ps
// Bench for avalon_packet_arbiter: a directed vector table, hand-written
// multi-cycle sequences and a randomized run against a cycle-level model.
module tb_avalon_packet_arbiter;
    localparam int NB = 16;
    localparam int N  = 4;
    localparam int DW = 8 * NB;
    localparam int EW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) in_if [N] ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) out_if ();

    logic [N-1:0] grant_onehot;
    logic         busy;
    logic [N-1:0] dropped_beat_indi;

    avalon_packet_arbiter #(.DATA_WIDTH_IN_BYTES(NB), .NUM_INPUTS(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_msg            (in_if),
        .out_msg           (out_if),
        .grant_onehot      (grant_onehot),
        .busy              (busy),
        .dropped_beat_indi (dropped_beat_indi)
    );

    // Stimulus side
    logic [N-1:0]  t_valid, t_sop, t_eop;
    logic [DW-1:0] t_data  [N];
    logic [EW-1:0] t_empty [N];
    logic          t_ordy;
    logic [N-1:0]  d_rdy;

    for (genvar g = 0; g < N; g++) begin : g_drv
        assign in_if[g].valid = t_valid[g];
        assign in_if[g].sop   = t_sop[g];
        assign in_if[g].eop   = t_eop[g];
        assign in_if[g].data  = t_data[g];
        assign in_if[g].empty = t_empty[g];
        assign d_rdy[g]       = in_if[g].rdy;
    end
    assign out_if.rdy = t_ordy;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    // Per-input source queues (circular buffers of beats)
    typedef struct {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
    } beat_t;
    beat_t        qmem [N][64];
    int           qh [N];
    int           qt [N];
    logic [N-1:0] en;
    int           pkt_id = 0;

    // Output log: src*256 + beat index of every accepted output beat
    int olog[$];
    int sop_src[$];
    int gaps[$];
    int last_eop_cyc = 0;

    // Reference model: owner of the output (-1 when idle) and last served input
    int m_owner = -1;
    int m_last  = N - 1;

    logic [N-1:0]  e_rdy, e_drop, e_grant;
    logic          e_busy, e_ov, e_osop, e_oeop;
    logic [DW-1:0] e_odata;
    logic [EW-1:0] e_oempty;

    task automatic model_eval();
        if (!rst) begin
            m_owner = -1;
            m_last  = N - 1;
        end
        e_rdy = '0; e_drop = '0; e_grant = '0; e_busy = 1'b0;
        e_ov = 1'b0; e_osop = 1'b0; e_oeop = 1'b0; e_odata = '0; e_oempty = '0;
        if (m_owner >= 0) begin
            e_busy         = 1'b1;
            e_grant        = 4'(1 << m_owner);
            e_ov           = t_valid[m_owner];
            e_osop         = t_sop[m_owner];
            e_oeop         = t_eop[m_owner];
            e_odata        = t_data[m_owner];
            e_oempty       = t_empty[m_owner];
            e_rdy[m_owner] = t_ordy;
        end else if (rst) begin
            for (int i = 0; i < N; i++) begin
                if (t_valid[i] && !t_sop[i]) begin
                    e_rdy[i]  = 1'b1;
                    e_drop[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_step();
        int  c;
        bit  found;
        if (!rst) begin
            m_owner = -1;
            m_last  = N - 1;
        end else if (m_owner < 0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && t_valid[c] && t_sop[c]) begin
                    m_owner = c;
                    found   = 1;
                end
            end
        end else if (t_valid[m_owner] && t_ordy && t_eop[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
    endtask

    task automatic check(input string name);
        model_eval();
        n_vec++;
        if ({out_if.valid, out_if.sop, out_if.eop, out_if.empty, out_if.data, d_rdy,
             dropped_beat_indi, busy, grant_onehot} !==
            {e_ov, e_osop, e_oeop, e_oempty, e_odata, e_rdy, e_drop, e_busy, e_grant}) begin
            n_miss++;
            $display("FAIL %s cyc=%0d: got v=%b s=%b e=%b emp=%h rdy=%b drop=%b busy=%b gnt=%b data=%h | want v=%b s=%b e=%b emp=%h rdy=%b drop=%b busy=%b gnt=%b data=%h",
                     name, cyc, out_if.valid, out_if.sop, out_if.eop, out_if.empty, d_rdy,
                     dropped_beat_indi, busy, grant_onehot, out_if.data,
                     e_ov, e_osop, e_oeop, e_oempty, e_rdy, e_drop, e_busy, e_grant, e_odata);
        end
    endtask

    task automatic cycle(input string name);
        int src;
        #2;
        check(name);
        if (rst && out_if.valid && t_ordy) begin
            src = int'(out_if.data[DW-1:DW-8]);
            olog.push_back(src * 256 + int'(out_if.data[DW-17:DW-24]));
            if (out_if.sop) begin
                sop_src.push_back(src);
                gaps.push_back(cyc - last_eop_cyc);
            end
            if (out_if.eop) last_eop_cyc = cyc;
        end
        for (int i = 0; i < N; i++) begin
            if (en[i] && t_valid[i] && d_rdy[i] && qh[i] != qt[i]) qh[i]++;
        end
        model_step();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mkdata(input int src, input int pkt, input int beat);
        logic [DW-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        d[DW-1:DW-8]   = 8'(src);
        d[DW-9:DW-16]  = 8'(pkt);
        d[DW-17:DW-24] = 8'(beat);
        return d;
    endfunction

    task automatic push_beat(input int s, input logic sop, input logic eop, input int beat);
        beat_t b;
        b.sop   = sop;
        b.eop   = eop;
        b.data  = mkdata(s, pkt_id, beat);
        b.empty = eop ? EW'($urandom_range(0, 15)) : '0;
        qmem[s][qt[s] % 64] = b;
        qt[s]++;
    endtask

    task automatic push_packet(input int s, input int len);
        for (int b = 0; b < len; b++) push_beat(s, b == 0, b == len - 1, b);
        pkt_id++;
    endtask

    function automatic bit all_empty();
        bit r;
        r = 1;
        for (int i = 0; i < N; i++) if (qh[i] != qt[i]) r = 0;
        return r;
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            if (en[i] && qh[i] != qt[i]) begin
                t_valid[i] = 1'b1;
                t_sop[i]   = qmem[i][qh[i] % 64].sop;
                t_eop[i]   = qmem[i][qh[i] % 64].eop;
                t_data[i]  = qmem[i][qh[i] % 64].data;
                t_empty[i] = qmem[i][qh[i] % 64].empty;
            end else begin
                t_valid[i] = 1'b0;
                t_sop[i]   = 1'b0;
                t_eop[i]   = 1'b0;
                t_data[i]  = '0;
                t_empty[i] = '0;
            end
        end
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        if (!all_empty()) begin
            n_miss++;
            $display("FAIL %s_drain: source queues still hold beats after cycle budget, want empty", name);
        end
    endtask

    task automatic compare_q(input string name, input int act[$], input int exp[$]);
        n_vec++;
        if (act.size() != exp.size()) begin
            n_miss++;
            $display("FAIL %s_len: got %0d entries, want %0d", name, act.size(), exp.size());
        end
        for (int k = 0; k < exp.size(); k++) begin
            n_vec++;
            if (k >= act.size() || act[k] != exp[k]) begin
                n_miss++;
                $display("FAIL %s[%0d]: got %0d, want %0d", name, k,
                         (k < act.size()) ? act[k] : -1, exp[k]);
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            qh[i] = 0; qt[i] = 0;
            t_data[i] = '0; t_empty[i] = '0;
        end
        en = '0;
        t_ordy = 1'b1;
        // stray-looking beats on every input while reset is held
        t_valid = '1; t_sop = '0; t_eop = '0;
        cycle("reset_hold");
        t_valid = '0;
        cycle("reset_idle");
        rst = 1'b1;
        olog.delete(); sop_src.delete(); gaps.delete();
        last_eop_cyc = 0;
    endtask

    // Directed vector table
    typedef struct {
        logic [N-1:0] v, s, e;
        logic         ordy;
        logic [N-1:0] x_rdy, x_drop, x_grant;
        logic         x_busy, x_ov, x_osop, x_oeop;
        int           x_src;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                                input logic o, input logic [3:0] xr, input logic [3:0] xd,
                                input logic [3:0] xg, input logic xb, input logic xov,
                                input logic xs, input logic xe, input int src);
        vec_t r;
        r.v = v; r.s = s; r.e = e; r.ordy = o;
        r.x_rdy = xr; r.x_drop = xd; r.x_grant = xg;
        r.x_busy = xb; r.x_ov = xov; r.x_osop = xs; r.x_oeop = xe; r.x_src = src;
        return r;
    endfunction

    localparam int NT = 23;
    vec_t          tbl [NT];
    logic [DW-1:0] x_data;
    logic [EW-1:0] x_empty;
    int            exp_q[$];

    initial begin
        rst = 1'b0;
        t_valid = '0; t_sop = '0; t_eop = '0; t_ordy = 1'b1; en = '0;
        for (int i = 0; i < N; i++) begin
            qh[i] = 0; qt[i] = 0; t_data[i] = '0; t_empty[i] = '0;
        end
        #1;

        //          v     s     e    o   rdy   drop  gnt  b  ov s  e  src
        tbl[0]  = mk(4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, -1);
        tbl[1]  = mk(4'h4, 4'h4, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, -1);
        tbl[2]  = mk(4'h4, 4'h4, 4'h0, 1, 4'h4, 4'h0, 4'h4, 1, 1, 1, 0,  2);
        tbl[3]  = mk(4'h4, 4'h0, 4'h0, 1, 4'h4, 4'h0, 4'h4, 1, 1, 0, 0,  2);
        tbl[4]  = mk(4'h4, 4'h0, 4'h4, 1, 4'h4, 4'h0, 4'h4, 1, 1, 0, 1,  2);
        tbl[5]  = mk(4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, -1);
        tbl[6]  = mk(4'h1, 4'h0, 4'h0, 1, 4'h1, 4'h1, 4'h0, 0, 0, 0, 0, -1);
        tbl[7]  = mk(4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, -1);
        tbl[8]  = mk(4'h8, 4'h8, 4'h8, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, -1);
        tbl[9]  = mk(4'h8, 4'h8, 4'h8, 1, 4'h8, 4'h0, 4'h8, 1, 1, 1, 1,  3);
        tbl[10] = mk(4'hB, 4'hB, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, -1);
        tbl[11] = mk(4'hB, 4'hB, 4'h0, 1, 4'h1, 4'h0, 4'h1, 1, 1, 1, 0,  0);
        tbl[12] = mk(4'hB, 4'hA, 4'h1, 0, 4'h0, 4'h0, 4'h1, 1, 1, 0, 1,  0);
        tbl[13] = mk(4'hB, 4'hA, 4'h1, 1, 4'h1, 4'h0, 4'h1, 1, 1, 0, 1,  0);
        tbl[14] = mk(4'hA, 4'hA, 4'h2, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, -1);
        tbl[15] = mk(4'hA, 4'hA, 4'h2, 1, 4'h2, 4'h0, 4'h2, 1, 1, 1, 1,  1);
        tbl[16] = mk(4'h8, 4'h8, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, -1);
        tbl[17] = mk(4'h8, 4'h8, 4'h0, 1, 4'h8, 4'h0, 4'h8, 1, 1, 1, 0,  3);
        tbl[18] = mk(4'h8, 4'h0, 4'h8, 1, 4'h8, 4'h0, 4'h8, 1, 1, 0, 1,  3);
        tbl[19] = mk(4'h5, 4'h4, 4'h0, 1, 4'h1, 4'h1, 4'h0, 0, 0, 0, 0, -1);
        tbl[20] = mk(4'h5, 4'h4, 4'h4, 1, 4'h4, 4'h0, 4'h4, 1, 1, 1, 1,  2);
        tbl[21] = mk(4'h1, 4'h0, 4'h0, 1, 4'h1, 4'h1, 4'h0, 0, 0, 0, 0, -1);
        tbl[22] = mk(4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, -1);

        reset_dut();

        // ---- directed table ----
        for (int i = 0; i < N; i++) begin
            t_data[i]  = {4{32'hA500_0000 | 32'(i)}};
            t_empty[i] = EW'(i * 5);
        end
        for (int r = 0; r < NT; r++) begin
            t_valid = tbl[r].v; t_sop = tbl[r].s; t_eop = tbl[r].e; t_ordy = tbl[r].ordy;
            #2;
            x_data  = (tbl[r].x_src >= 0) ? t_data[tbl[r].x_src]  : '0;
            x_empty = (tbl[r].x_src >= 0) ? t_empty[tbl[r].x_src] : '0;
            n_vec++;
            if ({d_rdy, dropped_beat_indi, grant_onehot, busy, out_if.valid, out_if.sop,
                 out_if.eop, out_if.empty, out_if.data} !==
                {tbl[r].x_rdy, tbl[r].x_drop, tbl[r].x_grant, tbl[r].x_busy, tbl[r].x_ov,
                 tbl[r].x_osop, tbl[r].x_oeop, x_empty, x_data}) begin
                n_miss++;
                $display("FAIL tbl[%0d]: got rdy=%b drop=%b gnt=%b busy=%b v=%b s=%b e=%b emp=%h data=%h | want rdy=%b drop=%b gnt=%b busy=%b v=%b s=%b e=%b emp=%h data=%h",
                         r, d_rdy, dropped_beat_indi, grant_onehot, busy, out_if.valid,
                         out_if.sop, out_if.eop, out_if.empty, out_if.data,
                         tbl[r].x_rdy, tbl[r].x_drop, tbl[r].x_grant, tbl[r].x_busy,
                         tbl[r].x_ov, tbl[r].x_osop, tbl[r].x_oeop, x_empty, x_data);
            end
            @(posedge clk);
            #1;
        end

        // ---- all four requesting at once, 2-beat packets, two rounds ----
        reset_dut();
        for (int i = 0; i < N; i++) begin
            push_packet(i, 2);
            push_packet(i, 2);
        end
        en = '1; t_ordy = 1'b1;
        for (int k = 0; k < 80 && !all_empty(); k++) begin
            drive_sources();
            cycle("rr");
        end
        check_drained("rr");
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        compare_q("rr_order", sop_src, exp_q);
        exp_q = '{2, 2, 2, 2, 2, 2, 2};
        if (gaps.size() > 0) void'(gaps.pop_front());
        compare_q("rr_gap", gaps, exp_q);

        // ---- backpressure on granted input 1 while input 3 waits ----
        reset_dut();
        push_packet(1, 4);
        en = 4'b0010; t_ordy = 1'b1;
        drive_sources();
        cycle("bp_arb");
        push_packet(3, 2);
        en = 4'b1010;
        for (int k = 0; k < 60 && !all_empty(); k++) begin
            t_ordy = (k % 2 == 0);
            drive_sources();
            cycle("bp");
        end
        check_drained("bp");
        exp_q = '{256, 257, 258, 259, 768, 769};
        compare_q("bp_log", olog, exp_q);

        // ---- reset during beat 2 of a 4-beat packet ----
        reset_dut();
        push_packet(2, 4);
        en = 4'b0100; t_ordy = 1'b1;
        drive_sources(); cycle("rst_arb");
        drive_sources(); cycle("rst_beat1");
        drive_sources();
        rst = 1'b0;
        cycle("rst_mid");
        #1;
        n_vec++;
        if ({out_if.valid, busy, grant_onehot, d_rdy, dropped_beat_indi} !== '0) begin
            n_miss++;
            $display("FAIL rst_mid_outputs: got v=%b busy=%b gnt=%b rdy=%b drop=%b, want all zero",
                     out_if.valid, busy, grant_onehot, d_rdy, dropped_beat_indi);
        end
        rst = 1'b1;
        olog.delete(); sop_src.delete(); gaps.delete();
        push_packet(0, 1);
        push_packet(1, 2);
        en = 4'b0111;
        drive_sources();
        cycle("post_rst_arb");
        #1;
        n_vec++;
        if (grant_onehot !== 4'b0001) begin
            n_miss++;
            $display("FAIL post_rst_grant: got %b, want 0001", grant_onehot);
        end
        for (int k = 0; k < 40 && !all_empty(); k++) begin
            drive_sources();
            cycle("post_rst");
        end
        check_drained("post_rst");
        exp_q = '{0, 256, 257};
        compare_q("post_rst_log", olog, exp_q);

        // ---- randomized traffic against the model ----
        reset_dut();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (qh[i] == qt[i]) begin
                    int r;
                    r = $urandom_range(0, 99);
                    if (r < 8) begin
                        push_beat(i, 1'b0, 1'($urandom_range(0, 1)), 0);
                        pkt_id++;
                    end else if (r < 40) begin
                        push_packet(i, $urandom_range(1, 5));
                    end
                end
                en[i] = ($urandom_range(0, 99) < 85);
            end
            t_ordy = ($urandom_range(0, 99) < 75);
            drive_sources();
            cycle("rand");
        end
        en = '1; t_ordy = 1'b1;
        for (int k = 0; k < 300 && !all_empty(); k++) begin
            drive_sources();
            cycle("rand_drain");
        end
        check_drained("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/avalon_packet_arbiter.md
# avalon_packet_arbiter

Packet-level round-robin arbiter that shares one Avalon-ST output stream between NUM_INPUTS Avalon-ST requesters. Each input is expected to come from an avalon_enforcer instance, so packets arrive framed with sop/eop. The arbiter grants one input per packet and holds that grant until the granted packet's eop beat is accepted. It sits between the per-source enforcers and the shared downstream consumer.

## Interface
- DATA_WIDTH_IN_BYTES, 16, byte width of data on all streams; empty is $clog2(DATA_WIDTH_IN_BYTES) bits
- NUM_INPUTS, 4, number of requesters; legal range 2..16
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_msg[NUM_INPUTS]  avalon_st_if.slave  DATA_WIDTH_IN_BYTES  requester streams (data, valid, sop, eop, empty in; rdy out)
- out_msg  avalon_st_if.master  DATA_WIDTH_IN_BYTES  shared output stream
- grant_onehot  out  NUM_INPUTS  one-hot index of the currently granted input; all zero when idle
- busy  out  1  high while a packet is in transfer
- dropped_beat_indi  out  NUM_INPUTS  one-cycle pulse per input when a stray beat is discarded while idle

## Operation
- The FSM has two states, IDLE and TRANSFER. Reset state is IDLE, with last_grant = NUM_INPUTS-1, so input 0 has the highest priority first.
- IDLE:
  - out_msg.valid = 0; out_msg data, sop, eop and empty are driven to 0.
  - Candidates are the inputs with valid && sop. The winner is the first candidate scanning last_grant+1, last_grant+2, … modulo NUM_INPUTS.
  - If a winner exists, on the clock edge: grant <= winner, state <= TRANSFER. No beat is consumed in this cycle, so all candidates see rdy = 0.
  - Stray beats (valid && !sop) in IDLE are discarded. For each such input, rdy = 1 and dropped_beat_indi[i] pulses for that cycle.
- TRANSFER:
  - out_msg data, valid, sop, eop and empty pass combinationally from in_msg[grant].
  - in_msg[grant].rdy = out_msg.rdy. All other rdy = 0, and ungranted inputs are never dropped in this state.
  - When out_msg.valid && out_msg.rdy && out_msg.eop: state <= IDLE, last_grant <= grant.
  - An sop beat inside a granted packet is forwarded unchanged. The arbiter does not re-check framing.
- A single-beat packet (sop && eop) is granted, then transferred, then released: one IDLE cycle, then one TRANSFER cycle when rdy = 1.
- grant_onehot = (state == TRANSFER) ? 1 << grant : 0. busy = (state == TRANSFER).

## Timing
- Arbitration latency: there is exactly one IDLE cycle between a packet's eop acceptance and the next packet's first beat. A winner's first beat appears on out_msg one cycle after its valid && sop is first sampled in IDLE.
- Data path: zero-latency combinational mux in TRANSFER. There are no registers in the data path.
- Backpressure: out_msg.rdy low stalls the granted input only. The grant never changes mid-packet, regardless of the rdy pattern.
- If the granted input drops valid mid-packet, the arbiter stays in TRANSFER with out_msg.valid = 0 until the packet resumes. There is no timeout.
- Simultaneous requests: exactly one winner per IDLE cycle, chosen by the rotating priority. The losers keep valid && sop asserted and compete again after the current packet ends.
- If reset asserts mid-packet, state, grant and last_grant reset immediately. Outputs go to their reset values: valid = 0, all rdy = 0, grant_onehot = 0, busy = 0, dropped_beat_indi = 0. The partial packet is truncated downstream.
- All outputs are well defined while rst is low. No X propagates from inputs into rdy or indicator outputs.

## Test plan
- Single requester, 3-beat packet on input 2 with out rdy = 1 → grant_onehot = 4'b0100 one cycle after sop is sampled; 3 beats pass in order; busy drops the cycle after eop; empty is passed through unchanged.
- All 4 inputs present valid && sop simultaneously, 2-beat packets, repeated → service order is 0, 1, 2, 3, 0, … with exactly one idle cycle between packets.
- Granted input 1, out rdy toggling 1-0-1-0 mid-packet, input 3 requesting → no beat lost or duplicated; input 3 sees rdy = 0 throughout; grant switches to 3 only after input 1's eop is accepted.
- Stray beat on input 0 (valid = 1, sop = 0) in IDLE → in_msg[0].rdy = 1, dropped_beat_indi = 4'b0001 for one cycle, out_msg.valid = 0, no grant issued.
- Single-beat packet (sop = eop = 1, empty = 4'hF) on input 3 → exactly one output beat with sop = eop = 1, empty = 4'hF; the FSM returns to IDLE; the next priority scan starts at input 0.
- Assert rst = 0 during beat 2 of a 4-beat packet → next sample shows out_msg.valid = 0, busy = 0, grant_onehot = 0. After release, an input-1 sop request is granted within 2 cycles, with input 0 having the highest priority.
